// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_cnt.sv
// Frame bit counter: clear has priority over load-of-1, which beats increment.
// term flags that N-1 bits are already in, so the next shifted bit completes the word.
module shift_deser_cnt #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load1,
  input  logic inc,
  output logic term
);

  logic [CW-1:0] cnt;

  // Count received bits of the current frame
  always_ff @(posedge clk) begin
    if (reset || clear)  cnt <= '0;
    else if (load1)      cnt <= CW'(1);
    else if (inc)        cnt <= cnt + CW'(1);
  end

  assign term = (cnt == CW'(N - 1));

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with start-of-frame marker, selectable bit
// order, a one-word output buffer (q/valid) and a sticky overrun flag.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         start,
  input  logic         sin,
  input  logic         dir,
  input  logic         ready,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         busy,
  output logic         overrun
);

  state_t       state;
  logic [N-1:0] sr;
  logic [N-1:0] sr_shift;
  logic         dir_q;
  logic         restart;
  logic         shift_bit;
  logic         term;
  logic         complete;

  // A start strobe always opens a fresh frame, whether idle or mid-frame
  assign restart   = en & start;
  assign shift_bit = (state == SHIFT) & en & ~start;
  assign complete  = shift_bit & term;
  assign busy      = (state == SHIFT);

  assign sr_shift = (dir_q == DIR_LSB_FIRST) ? {sin, sr[N-1:1]}
                                             : {sr[N-2:0], sin};

  shift_deser_cnt #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (complete),
    .load1 (restart),
    .inc   (shift_bit & ~term),
    .term  (term)
  );

  // Frame FSM, shift register and output buffer; completed word goes straight to q
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      dir_q   <= DIR_MSB_FIRST;
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (restart) begin
        state <= SHIFT;
        dir_q <= dir;
        sr    <= (dir == DIR_LSB_FIRST) ? {sin, {(N-1){1'b0}}}
                                        : {{(N-1){1'b0}}, sin};
      end else if (shift_bit) begin
        sr <= sr_shift;
        if (term) state <= IDLE;
      end

      if (complete) begin
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          q     <= sr_shift;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench for shift_deser: a frame-level reference model predicts
// words into a queue; a monitor pops and compares on every q/valid handshake.
module tb_shift_deser;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, start = 1'b0, sin = 1'b0, dir = 1'b0, ready = 1'b0;
  logic [N-1:0] q;
  logic         valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];

  // Reference model state: frame bits as received, plus output buffer flags
  bit   fbits[$];
  bit   fdir    = 1'b0;
  bit   in_fr   = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_ovr   = 1'b0;

  shift_deser #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .start   (start),
    .sin     (sin),
    .dir     (dir),
    .ready   (ready),
    .q       (q),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: compare flags left by the previous edge, then apply this cycle's inputs
  always @(negedge clk) begin
    logic [N-1:0] w;
    bit done;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(in_fr));
    if (reset) begin
      fbits.delete();
      in_fr = 0; m_valid = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      done = 0;
      w = '0;
      if (en) begin
        if (start) begin
          fbits.delete();
          fbits.push_back(sin);
          fdir  = dir;
          in_fr = 1;
        end else if (in_fr) begin
          fbits.push_back(sin);
          if (fbits.size() == N) begin
            for (int i = 0; i < N; i++)
              if (fdir) w[i] = fbits[i];
              else      w[N-1-i] = fbits[i];
            done  = 1;
            in_fr = 0;
          end
        end
      end
      if (done) begin
        if (m_valid && !ready) m_ovr = 1;
        else begin
          exp_q.push_back(w);
          m_valid = 1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  end

  // Monitor: every accepted word must match the oldest predicted word
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1 && reset === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty got word %0h expected none", q);
      end else begin
        chk("q_pop", 32'(q), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic e, input logic s, input logic b, input logic d, input logic r);
    @(posedge clk); #1;
    en = e; start = s; sin = b; dir = d; ready = r;
  endtask

  // Send one 4-bit frame, first bit = bits[3]; ready is raised only on the last bit
  task automatic frame(input logic [3:0] bits, input logic d, input bit gaps, input logic r_last);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, d, 1'b0);
      cyc(1'b1, (i == 0), bits[3-i], d, (i == N-1) ? r_last : 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_q", 32'(q), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);

    // MSB-first 1,0,1,1
    frame(4'b1011, 1'b0, 0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("msb_q", 32'(q), 32'h0B);
    chk("msb_valid", 32'(valid), 1);
    chk("msb_busy", 32'(busy), 0);

    // Unconsumed word: next completion is dropped
    frame(4'b0001, 1'b0, 0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_q_held", 32'(q), 32'h0B);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_consumed", 32'(valid), 0);

    // LSB-first 1,0,1,1
    frame(4'b1011, 1'b1, 0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("lsb_q", 32'(q), 32'h0D);
    chk("ovr_sticky", 32'(overrun), 1);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-frame, with en active during the reset cycle
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mid_busy", 32'(busy), 1);
    @(posedge clk); #1 reset = 1; en = 1; sin = 1;
    @(posedge clk); #1 reset = 0; en = 0;
    chk("mrst_q", 32'(q), 0);
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ovr", 32'(overrun), 0);
    frame(4'b1100, 1'b0, 0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_q", 32'(q), 32'h0C);
    cyc(0, 0, 0, 0, 1);

    // Two bits, then restart with gaps
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    frame(4'b0110, 1'b0, 1, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("restart_q", 32'(q), 32'h06);
    chk("restart_ovr", 32'(overrun), 0);

    // Completion in the same cycle as a consume
    frame(4'b1001, 1'b0, 0, 1'b1);
    cyc(0, 0, 0, 0, 0);
    chk("pass_q", 32'(q), 32'h09);
    chk("pass_valid", 32'(valid), 1);
    chk("pass_ovr", 32'(overrun), 0);
    cyc(0, 0, 0, 0, 1);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) < 2);
      en    = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 99) < 15);
      sin   = 1'($urandom_range(0, 1));
      dir   = 1'($urandom_range(0, 1));
      ready = reset ? 1'b0 : 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 reset = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("drain_empty", 32'(exp_q.size()), 0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 SHALL have parameter N, default 4, meaning parallel word width in bits; legal range N >= 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  bit strobe; sin/start/dir are sampled only when en=1.
REQ-005 SHALL have port start  input  1  marks the first bit of a frame when sampled with en=1.
REQ-006 SHALL have port sin  input  1  serial data bit.
REQ-007 SHALL have port dir  input  1  bit order: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
REQ-008 SHALL have port ready  input  1  consumer accepts q when valid=1.
REQ-009 SHALL have port q  output  N  received parallel word, held until consumed.
REQ-010 SHALL have port valid  output  1  q holds an unconsumed word.
REQ-011 SHALL have port busy  output  1  a frame is partially received.
REQ-012 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT, plus an internal N-bit shift register sr, a bit counter cnt, a latched direction bit, and a separate output register q/valid.
REQ-014 In IDLE, en=1 with start=0 SHALL be ignored; en=1 with start=1 SHALL capture sin as bit 1, latch dir, set cnt=1, and go to SHIFT.
REQ-015 Shift rule: latched dir=0 -> sr <= {sr[N-2:0], sin}; latched dir=1 -> sr <= {sin, sr[N-1:1]}. After N bits, the first bit received sits in the MSB (dir=0) or the LSB (dir=1).
REQ-016 In SHIFT, en=0 SHALL hold sr, cnt and state unchanged, so strobe gaps of any length are legal.
REQ-017 In SHIFT, en=1 with start=0 SHALL shift in sin and increment cnt.
REQ-018 In SHIFT, en=1 with start=1 SHALL abort the partial frame and restart it: discard sr, capture this bit as bit 1, relatch dir, set cnt=1.
REQ-019 On capture of the Nth bit, the state SHALL return to IDLE, and the completed word SHALL transfer to q with valid=1 on the following clock edge (latency 1 cycle after the Nth en).
REQ-020 valid SHALL clear on the edge where valid=1 and ready=1, unless a new word transfers in the same cycle.
REQ-021 Completion with valid=1 and ready=1 in the same cycle SHALL load the new word, keep valid=1, and leave overrun unchanged.
REQ-022 Completion with valid=1 and ready=0 SHALL drop the new word, leave q unchanged, and set overrun=1.
REQ-023 overrun SHALL remain 1 until reset.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 A new frame SHALL be allowed to start the cycle after completion, while valid is still 1 (double buffering).

Reset
REQ-026 reset=1 at a clock edge SHALL force state=IDLE, sr=0, cnt=0, q=0, valid=0, busy=0, overrun=0, overriding all other inputs, including mid-frame and during a completion cycle.
REQ-027 The first en/start after reset deasserts SHALL be processed normally.

Structure
REQ-028 Package shift_deser_pkg SHALL hold the state enum (IDLE, SHIFT) and the constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
REQ-029 Bit counting SHALL live in one sub-module shift_deser_cnt (width $clog2(N+1), with clear/load-1/increment controls and a terminal flag at N-1); everything else SHALL stay in shift_deser.

Verification
REQ-030 N=4, dir=0, start with bit 1, then bits 0,1,1 on consecutive en -> q=4'b1011, valid=1 one cycle after the 4th en, busy=0.
REQ-031 N=4, dir=1, same bit sequence 1,0,1,1 -> q=4'b1101.
REQ-032 ready held 0 after q=4'b1011; send frame 0,0,0,1 -> overrun=1, q stays 4'b1011. Then ready=1 for one cycle -> valid=0.
REQ-033 Send 2 bits, then start a new frame 0,1,1,0 with dir=0 and random en gaps -> q=4'b0110, no overrun.
REQ-034 Assert reset after 3 bits of a frame -> next cycle q=0, valid=0, busy=0, overrun=0; a subsequent full frame decodes correctly.
REQ-035 Completion cycle coincides with valid=1 and ready=1 -> new word in q, valid stays 1, overrun=0.
